census_disp_window: RTL

//  Builds the per-pixel disparity search window that feeds SGMCore. Accepts a raster

---
 rtl/census_disp_window.sv | 79 +++++++
 1 files changed

// File: rtl/census_disp_window.sv
// Disparity search window builder: shifts right census vectors per row and
// presents them alongside the left vector, raster position and edge flag.
module census_disp_window #(
    parameter int censusVecW = 24,
    parameter int dispLevel  = 32,
    parameter int ImageW     = 640,
    parameter int ImageH     = 480
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              in_valid,
    input  logic [censusVecW-1:0]             censusL,
    input  logic [censusVecW-1:0]             censusR,
    output logic [censusVecW*dispLevel-1:0]   LineData,
    output logic [censusVecW-1:0]             PixData,
    output logic                              IsOnEdge,
    output logic                              out_valid,
    output logic [$clog2(ImageW)-1:0]         col,
    output logic [$clog2(ImageH)-1:0]         row,
    output logic                              frame_end
);

    localparam int CW = $clog2(ImageW);
    localparam int RW = $clog2(ImageH);
    localparam logic [CW-1:0] EDGE_COL = CW'(dispLevel - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(ImageW - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(ImageH - 1);

    logic [dispLevel-1:0][censusVecW-1:0] win;
    logic [CW-1:0] next_col;
    logic [RW-1:0] next_row;
    logic          last_col;
    logic          last_row;
    logic          row_start;

    assign last_col  = (next_col == LAST_COL);
    assign last_row  = (next_row == LAST_ROW);
    assign row_start = (next_col == '0);
    assign LineData  = win;

    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= '0;
            PixData   <= '0;
            out_valid <= 1'b0;
            IsOnEdge  <= 1'b1;
            col       <= '0;
            row       <= '0;
            frame_end <= 1'b0;
            next_col  <= '0;
            next_row  <= '0;
        end else if (en) begin
            if (in_valid) begin
                // A new row starts with an empty window so no data leaks across rows
                if (row_start)
                    win <= {{((dispLevel - 1) * censusVecW){1'b0}}, censusR};
                else
                    win <= {win[dispLevel-2:0], censusR};
                PixData   <= censusL;
                IsOnEdge  <= (next_col < EDGE_COL) || (next_row == '0);
                col       <= next_col;
                row       <= next_row;
                out_valid <= 1'b1;
                frame_end <= last_col && last_row;
                if (last_col) begin
                    next_col <= '0;
                    next_row <= last_row ? '0 : next_row + 1'b1;
                end else begin
                    next_col <= next_col + 1'b1;
                end
            end else begin
                out_valid <= 1'b0;
                frame_end <= 1'b0;
            end
        end
    end

endmodule
